fetch_decode: RTL

- Front-end stage of the RV32I core; sits directly upstream of the controller.
- Owns the PC and fetches instructions over a valid/ready instruction-memory port.
- Decodes each fetched word into op_type, funct3, funct7, register indices and a sign-extended immediate.
- Presents one instruction per commit pulse; updates the PC from the controller's sel_pc and the datapath jump/branch target.

---
 rtl/lib_pkg.sv | 64 ++++++
 rtl/imm_gen.sv | 43 ++++
 rtl/fetch_decode.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/lib_pkg.sv
// Shared types for the RV32I front end: opcode classes,
// opcode encodings, fetch FSM states and the NOP word.
package lib_pkg;

  typedef enum logic [3:0] {
    OP_LUI,
    OP_AUIPC,
    OP_JAL,
    OP_JALR,
    OP_BRANCH,
    OP_LOAD,
    OP_STORE,
    OP_OPIMM,
    OP_OP,
    OP_MISCMEM,
    OP_SYSTEM,
    OP_ILLEGAL
  } op_type_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    EXEC,
    HALT
  } fetch_state_t;

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic op_type_t decode_op(
    input logic [6:0] opc
  );
    op_type_t t;
    t = OP_ILLEGAL;
    case (opc)
      OPC_LUI:     t = OP_LUI;
      OPC_AUIPC:   t = OP_AUIPC;
      OPC_JAL:     t = OP_JAL;
      OPC_JALR:    t = OP_JALR;
      OPC_BRANCH:  t = OP_BRANCH;
      OPC_LOAD:    t = OP_LOAD;
      OPC_STORE:   t = OP_STORE;
      OPC_OPIMM:   t = OP_OPIMM;
      OPC_OP:      t = OP_OP;
      OPC_MISCMEM: t = OP_MISCMEM;
      OPC_SYSTEM:  t = OP_SYSTEM;
      default:     t = OP_ILLEGAL;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: instr, op_type -> sign-extended imm.
// Ports: instr (32), op_type (op_type_t) in; imm (32) out.
module imm_gen
  import lib_pkg::*;
(
  input  logic [31:0] instr,
  input  op_type_t    op_type,
  output logic [31:0] imm
);

  logic [31:0] i_imm;
  logic [31:0] s_imm;
  logic [31:0] b_imm;
  logic [31:0] u_imm;
  logic [31:0] j_imm;
  logic        unused_ok;

  assign i_imm = {{20{instr[31]}}, instr[31:20]};
  assign s_imm = {{20{instr[31]}}, instr[31:25],
                  instr[11:7]};
  assign b_imm = {{19{instr[31]}}, instr[31], instr[7],
                  instr[30:25], instr[11:8], 1'b0};
  assign u_imm = {instr[31:12], 12'b0};
  assign j_imm = {{11{instr[31]}}, instr[31],
                  instr[19:12], instr[20],
                  instr[30:21], 1'b0};

  assign unused_ok = ^instr[6:0];

  always_comb begin
    imm = 32'h0;
    unique case (op_type)
      OP_JALR, OP_LOAD, OP_OPIMM,
      OP_MISCMEM, OP_SYSTEM:   imm = i_imm;
      OP_STORE:                imm = s_imm;
      OP_BRANCH:               imm = b_imm;
      OP_LUI, OP_AUIPC:        imm = u_imm;
      OP_JAL:                  imm = j_imm;
      default:                 imm = 32'h0;
    endcase
  end

endmodule

// File: rtl/fetch_decode.sv
// RV32I fetch/decode stage: owns the PC, fetches over a valid/ready
// imem port, latches and decodes one instruction per commit pulse.
// Ports: clk, rst_n; imem req/rsp; sel_pc, fin, pc_target from the
// controller/ALU; pc, pc_plus4, instr, decode fields, imm,
// instr_valid, halted, illegal. Optional macro PC_MISALIGN_CHECK_EN
// adds a sticky 'misaligned' output for jump targets with bit 1 set.
module fetch_decode
  import lib_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        sel_pc,
  input  logic        fin,
  input  logic [31:0] pc_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr,
  output op_type_t    op_type,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [31:0] imm,
  output logic        instr_valid,
  output logic        halted,
`ifdef PC_MISALIGN_CHECK_EN
  output logic        misaligned,
`endif
  output logic        illegal
);

  fetch_state_t state;
  fetch_state_t state_n;

  logic        pc_we;
  logic        instr_we;
  logic        halt_set;
  logic        ill_set;
  logic        mis_hit;
  logic [31:0] pc_next;
  logic        unused_ok;

  assign unused_ok = pc_target[0];

`ifdef PC_MISALIGN_CHECK_EN
  assign mis_hit = sel_pc & pc_target[1];
`else
  assign mis_hit = 1'b0;
`endif

  assign op_type  = decode_op(instr[6:0]);
  assign funct3   = instr[14:12];
  assign funct7   = instr[31:25];
  assign rd       = instr[11:7];
  assign rs1      = instr[19:15];
  assign rs2      = instr[24:20];
  assign pc_plus4 = pc + 32'd4;
  assign imem_addr = pc;

  // Jump targets always land on an even address.
  assign pc_next = sel_pc ? {pc_target[31:1], 1'b0}
                          : pc_plus4;

  imm_gen u_imm_gen (
    .instr   (instr),
    .op_type (op_type),
    .imm     (imm)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n        = state;
    imem_req_valid = 1'b0;
    instr_valid    = 1'b0;
    pc_we          = 1'b0;
    instr_we       = 1'b0;
    halt_set       = 1'b0;
    ill_set        = 1'b0;
    unique case (state)
      IDLE: state_n = FETCH;
      FETCH: begin
        imem_req_valid = 1'b1;
        if (imem_req_ready) state_n = WAIT;
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          instr_we = 1'b1;
          state_n  = EXEC;
        end
      end
      EXEC: begin
        if (op_type == OP_ILLEGAL) begin
          ill_set  = 1'b1;
          halt_set = 1'b1;
          state_n  = HALT;
        end else begin
          instr_valid = 1'b1;
          if (fin || mis_hit) begin
            halt_set = 1'b1;
            state_n  = HALT;
          end else begin
            pc_we   = 1'b1;
            state_n = FETCH;
          end
        end
      end
      HALT: state_n = HALT;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      instr   <= NOP;
      halted  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      if (instr_we) instr   <= imem_rsp_data;
      if (pc_we)    pc      <= pc_next;
      if (halt_set) halted  <= 1'b1;
      if (ill_set)  illegal <= 1'b1;
    end
  end

`ifdef PC_MISALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      misaligned <= 1'b0;
    else if (instr_valid && !fin && mis_hit)
      misaligned <= 1'b1;
  end
`endif

endmodule
